mem_arbiter: RTL and testbench

// - Two-port front end for the single-port memory block: instruction-fetch (read-only) and load/store (read/write).
// - Arbitrates, latches one request, drives the memory's one-cycle Request_valid pulse, waits for Request_completed, returns data to the owner.
// - Sits between the core's fetch/LSU stages and memory; one access outstanding at a time.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory-side bus of mem_arbiter.
// Modports: slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if;
    logic        i_req;
    logic [26:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [26:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req_valid;
    logic        mem_re;
    logic        mem_we;
    logic [26:0] mem_read_addr;
    logic [26:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_req_completed;
    logic [31:0] mem_read_data;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  mem_req_completed, mem_read_data,
        output i_done, i_rdata, d_done, d_rdata, err,
        output mem_req_valid, mem_re, mem_we,
        output mem_read_addr, mem_write_addr, mem_write_data
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output mem_req_completed, mem_read_data,
        input  i_done, i_rdata, d_done, d_rdata, err,
        input  mem_req_valid, mem_re, mem_we,
        input  mem_read_addr, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch + load/store front end for a single-port memory, one access in flight.
// Ports: CLK, RST_N (async, active low), bus (mem_arbiter_if.slave: both request ports + memory side).
module mem_arbiter #(
    parameter bit          DATA_PRIORITY  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t        state, state_nxt;
    logic          owner_q;   // 1 = data port owns the access
    logic          last_d;    // last grant went to the data port
    logic          we_q;
    logic [26:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          grant_d;
    logic          any_req;
    logic          timeout_hit;

    always_comb begin
        grant_d = 1'b0;
        unique case (1'b1)
            bus.i_req && bus.d_req:  grant_d = DATA_PRIORITY ? 1'b1 : ~last_d;
            !bus.i_req && bus.d_req: grant_d = 1'b1;
            default:                 grant_d = 1'b0;
        endcase
    end

    assign any_req     = bus.i_req | bus.d_req;
    assign cnt_inc     = cnt + 1'b1;
    // Counter holds completed WAIT cycles; the exit fires on the cycle it would reach the limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.mem_req_completed || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            owner_q <= 1'b0;
            last_d  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= grant_d;
                        last_d  <= grant_d;
                        we_q    <= grant_d & bus.d_we;
                        addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                        wdata_q <= grant_d ? bus.d_wdata : 32'h0;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (bus.mem_req_completed) begin
                        rdata_q <= we_q ? 32'h0 : bus.mem_read_data;
                        err_q   <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout_hit) begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic issue, resp;
    assign issue = (state == ISSUE);
    assign resp  = (state == RESP);

    assign bus.mem_req_valid  = issue;
    assign bus.mem_re         = issue & ~we_q;
    assign bus.mem_we         = issue & we_q;
    assign bus.mem_read_addr  = addr_q;
    assign bus.mem_write_addr = addr_q;
    assign bus.mem_write_data = wdata_q;

    assign bus.i_done  = resp & ~owner_q;
    assign bus.d_done  = resp & owner_q;
    assign bus.i_rdata = bus.i_done ? rdata_q : 32'h0;
    assign bus.d_rdata = bus.d_done ? rdata_q : 32'h0;
    assign bus.err     = resp & err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random + directed scoreboard bench for mem_arbiter.
// Two instances: data-priority with timeout, and round-robin without timeout.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if a();
    mem_arbiter_if r();

    mem_arbiter #(.DATA_PRIORITY(1'b1), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(a)
    );
    mem_arbiter #(.DATA_PRIORITY(1'b0), .TIMEOUT_CYCLES(0)) dut_rr (
        .CLK(CLK), .RST_N(RST_N), .bus(r)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents seen by the environment, and the reference view of them.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [32:0] i_exp [$];
    logic [32:0] d_exp [$];

    bit stall     = 1'b0;
    bit fixed_lat = 1'b1;
    bit spur_en   = 1'b0;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // Environment memory: answers a request 1..3 cycles after mem_req_valid.
    int          pend;
    logic [7:0]  p_idx;
    logic        p_we;
    logic [31:0] p_wd;

    task mem_serve(input logic we, input logic [7:0] idx, input logic [31:0] wd);
        a.mem_req_completed <= 1'b1;
        if (we) mem[idx] <= wd;
        else a.mem_read_data <= mem[idx];
    endtask

    always @(posedge CLK or negedge RST_N) begin : mem_model
        int l;
        if (!RST_N) begin
            pend <= 0;
            a.mem_req_completed <= 1'b0;
            a.mem_read_data <= 32'h0;
        end else begin
            a.mem_req_completed <= 1'b0;
            a.mem_read_data <= 32'h0;
            if (a.mem_req_valid && !stall) begin
                l = fixed_lat ? 1 : int'($urandom_range(3, 1));
                if (l == 1) begin
                    mem_serve(a.mem_we, a.mem_read_addr[9:2], a.mem_write_data);
                end else begin
                    pend  <= l - 1;
                    p_idx <= a.mem_read_addr[9:2];
                    p_we  <= a.mem_we;
                    p_wd  <= a.mem_write_data;
                end
            end else if (a.mem_req_valid) begin
                pend <= 0;
            end else if (pend == 1) begin
                pend <= 0;
                mem_serve(p_we, p_idx, p_wd);
            end else if (pend > 1) begin
                pend <= pend - 1;
            end else if (spur_en && !stall && $urandom_range(3, 0) == 0) begin
                a.mem_req_completed <= 1'b1;
                a.mem_read_data <= $urandom;
            end
        end
    end

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r.mem_req_completed <= 1'b0;
            r.mem_read_data <= 32'h0;
        end else begin
            r.mem_req_completed <= r.mem_req_valid;
            r.mem_read_data <= r.mem_req_valid ? {5'b0, r.mem_read_addr} : 32'h0;
        end
    end

    // Monitor / scoreboard for the main instance.
    int          i_done_cnt = 0, d_done_cnt = 0;
    int          i_done_cyc = 0, d_done_cyc = 0, v_cyc = 0;
    logic        prev_v = 1'b0;
    logic        v_re, v_we;
    logic [26:0] v_addr;
    logic [31:0] v_wd;

    always @(negedge CLK) begin
        logic [32:0] e;
        if (!RST_N) begin
            prev_v = 1'b0;
        end else begin
            chk("valid_b2b", a.mem_req_valid & prev_v, 0);
            prev_v = a.mem_req_valid;
            chk("re_we_onehot", a.mem_re + a.mem_we, a.mem_req_valid);
            chk("one_done", a.i_done & a.d_done, 0);
            if (a.mem_req_valid) begin
                v_cyc = cyc;
                v_re = a.mem_re;
                v_we = a.mem_we;
                v_addr = a.mem_write_addr;
                v_wd = a.mem_write_data;
            end
            if (a.i_done) begin
                i_done_cnt++;
                i_done_cyc = cyc;
                if (i_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL i_unexpected_done: got i_done=1 expected none");
                end else begin
                    e = i_exp.pop_front();
                    chk("i_rdata", a.i_rdata, e[31:0]);
                    chk("i_err", a.err, e[32]);
                end
            end else begin
                chk("i_rdata_idle", a.i_rdata, 0);
            end
            if (a.d_done) begin
                d_done_cnt++;
                d_done_cyc = cyc;
                if (d_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL d_unexpected_done: got d_done=1 expected none");
                end else begin
                    e = d_exp.pop_front();
                    chk("d_rdata", a.d_rdata, e[31:0]);
                    chk("d_err", a.err, e[32]);
                end
            end else begin
                chk("d_rdata_idle", a.d_rdata, 0);
            end
            if (!a.i_done && !a.d_done) chk("err_idle", a.err, 0);
        end
    end

    // Grant order of the round-robin instance (1 = data).
    bit rr_seq [$];
    always @(negedge CLK) begin
        if (RST_N) begin
            if (r.i_done) begin
                rr_seq.push_back(1'b0);
                chk("rr_i_rdata", r.i_rdata, 32'h100);
            end
            if (r.d_done) begin
                rr_seq.push_back(1'b1);
                chk("rr_d_rdata", r.d_rdata, 32'h200);
            end
        end
    end

    task automatic do_fetch(input logic [26:0] addr, input bit exp_err);
        int k;
        int c0;
        @(posedge CLK);
        #1;
        if (exp_err) i_exp.push_back({1'b1, 32'h0});
        else i_exp.push_back({1'b0, ref_mem[addr[9:2]]});
        a.i_addr = addr;
        c0 = i_done_cnt;
        a.i_req = 1'b1;
        k = 0;
        while (i_done_cnt == c0 && k < 200) begin
            @(posedge CLK);
            k++;
        end
        if (i_done_cnt == c0) begin
            n_checks++;
            n_fail++;
            $display("FAIL i_wait: got no i_done expected one within 200 cycles");
        end
        #1 a.i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [26:0] addr, input logic [31:0] wd);
        int k;
        int c0;
        @(posedge CLK);
        #1;
        if (we) begin
            d_exp.push_back({1'b0, 32'h0});
            ref_mem[addr[9:2]] = wd;
        end else begin
            d_exp.push_back({1'b0, ref_mem[addr[9:2]]});
        end
        a.d_we = we;
        a.d_addr = addr;
        a.d_wdata = wd;
        c0 = d_done_cnt;
        a.d_req = 1'b1;
        k = 0;
        while (d_done_cnt == c0 && k < 200) begin
            @(posedge CLK);
            k++;
        end
        if (d_done_cnt == c0) begin
            n_checks++;
            n_fail++;
            $display("FAIL d_wait: got no d_done expected one within 200 cycles");
        end
        #1 a.d_req = 1'b0;
    endtask

    initial begin
        a.i_req = 0; a.i_addr = 0; a.d_req = 0; a.d_we = 0;
        a.d_addr = 0; a.d_wdata = 0;
        r.i_req = 0; r.i_addr = 27'h100; r.d_req = 0; r.d_we = 0;
        r.d_addr = 27'h200; r.d_wdata = 0;
        for (int k = 0; k < 256; k++) begin
            mem[k] = (32'(k) * 32'h0101_0101) ^ 32'hA500_0000;
            ref_mem[k] = mem[k];
        end
        mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mem_ctl", {a.mem_req_valid, a.mem_re, a.mem_we}, 0);
        chk("rst_done", {a.i_done, a.d_done, a.err}, 0);
        chk("rst_addr", a.mem_read_addr, 0);
        chk("rst_wdata", a.mem_write_data, 0);
        chk("rst_rdata", {a.i_rdata, a.d_rdata}, 0);
        RST_N = 1'b1;

        @(posedge CLK);
        #1;
        r.i_req = 1'b1;
        r.d_req = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        r.i_req = 1'b0;
        r.d_req = 1'b0;
        repeat (6) @(posedge CLK);
        chk("rr_count", rr_seq.size() >= 6, 1);
        for (int k = 0; k < 6 && k < rr_seq.size(); k++)
            chk($sformatf("rr_grant%0d", k), rr_seq[k], (k % 2 == 0));

        do_fetch(27'h10, 1'b0);
        chk("fetch_lat", i_done_cyc - v_cyc, 2);
        chk("fetch_re", {v_re, v_we}, 2'b10);

        do_data(1'b1, 27'h20, 32'h1234_5678);
        chk("store_we", {v_re, v_we}, 2'b01);
        chk("store_addr", v_addr, 27'h20);
        chk("store_wdata", v_wd, 32'h1234_5678);
        do_data(1'b0, 27'h20, 32'h0);

        fork
            do_fetch(27'h40, 1'b0);
            do_data(1'b0, 27'h300, 32'h0);
        join
        chk("tie_order", i_done_cyc - d_done_cyc, 4);

        stall = 1'b1;
        do_fetch(27'h44, 1'b1);
        chk("timeout_lat", i_done_cyc - v_cyc, 17);
        stall = 1'b0;
        do_fetch(27'h44, 1'b0);

        stall = 1'b1;
        @(posedge CLK);
        #1;
        a.i_addr = 27'h48;
        a.i_req = 1'b1;
        repeat (4) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rstmid_ctl", {a.mem_req_valid, a.mem_re, a.mem_we, a.i_done, a.d_done, a.err}, 0);
        chk("rstmid_addr", a.mem_read_addr, 0);
        a.i_req = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        stall = 1'b0;
        repeat (3) @(posedge CLK);
        do_fetch(27'h48, 1'b0);

        fixed_lat = 1'b0;
        spur_en = 1'b1;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic [26:0] ad;
                    ad = 27'($urandom);
                    ad[9] = 1'b0;
                    repeat ($urandom_range(3, 0)) @(posedge CLK);
                    do_fetch(ad, 1'b0);
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    logic [26:0] ad;
                    ad = 27'($urandom);
                    ad[9] = 1'b1;
                    repeat ($urandom_range(3, 0)) @(posedge CLK);
                    do_data(1'($urandom), ad, $urandom);
                end
            end
        join
        spur_en = 1'b0;
        repeat (10) @(posedge CLK);
        chk("i_exp_empty", i_exp.size(), 0);
        chk("d_exp_empty", d_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
